// File: rtl/ej32_pkg.sv
// Shared types and constants for the eJ32 image loader.
package ej32_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } ldr_st_t;

    localparam logic [1:0] LDR_E_NONE = 2'd0;
    localparam logic [1:0] LDR_E_OVF  = 2'd1;
    localparam logic [1:0] LDR_E_CSUM = 2'd2;

endpackage

// File: rtl/ej32_ldr_csum.sv
// 8-bit additive checksum accumulator; clear has priority over add.
// Sum reflects an added byte one cycle later; no backpressure.
module ej32_ldr_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= 8'd0;
        end else if (clr) begin
            sum <= 8'd0;
        end else if (add) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/ej32_rom_loader.sv
// Streams a length/payload/checksum framed image into the eJ32 image memory.
// Payload write one cycle after accept; s_ready is purely a function of state.
module ej32_rom_loader
    import ej32_pkg::*;
#(
    parameter  int ROM_SZ = 8192,
    parameter  int BASE_A = 0,
    localparam int MSZ    = $clog2(ROM_SZ)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           s_valid,
    input  logic [7:0]     s_data,
    output logic           s_ready,
    output logic           mem_we,
    output logic [MSZ-1:0] mem_a,
    output logic [7:0]     mem_d,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [1:0]     err_code,
    output logic [15:0]    wr_cnt
);

    localparam logic [16:0]    LEN_MAX = 17'(ROM_SZ - BASE_A);
    localparam logic [MSZ-1:0] A0      = MSZ'(BASE_A);

    ldr_st_t     st, st_nx;
    logic [15:0] len;
    logic [7:0]  sum;
    logic        xfer;
    logic        len_ovf;
    logic        last;
    logic        sum_clr;
    logic        sum_add;

    assign s_ready = (st == LEN_LO) || (st == LEN_HI) || (st == DATA) || (st == CSUM);
    assign xfer    = s_valid & s_ready;
    // Only meaningful in LEN_HI, where s_data carries the high length byte.
    assign len_ovf = {1'b0, s_data, len[7:0]} > LEN_MAX;
    assign last    = (wr_cnt + 16'd1) == len;
    assign sum_clr = (st == IDLE) && start;
    assign sum_add = (st == DATA) && xfer;

    ej32_ldr_csum u_csum (
        .clk (clk),
        .rst (rst),
        .clr (sum_clr),
        .add (sum_add),
        .din (s_data),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= IDLE;
        end else begin
            st <= st_nx;
        end
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:   if (start) st_nx = LEN_LO;
            LEN_LO: if (xfer) st_nx = LEN_HI;
            LEN_HI: begin
                if (xfer) begin
                    if (len_ovf)                      st_nx = ERR;
                    else if ({s_data, len[7:0]} == 0) st_nx = CSUM;
                    else                              st_nx = DATA;
                end
            end
            DATA:   if (xfer && last) st_nx = CSUM;
            CSUM:   if (xfer) st_nx = (s_data == sum) ? DONE : ERR;
            DONE:   st_nx = IDLE;
            ERR:    st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= LDR_E_NONE;
            wr_cnt   <= 16'd0;
            len      <= 16'd0;
            mem_we   <= 1'b0;
            mem_a    <= A0;
            mem_d    <= 8'd0;
        end else begin
            // Stays high through DONE/ERR so it falls together with the sticky flag.
            busy   <= (st_nx != IDLE);
            mem_we <= 1'b0;
            if (mem_we) begin
                mem_a <= mem_a + MSZ'(1);
            end
            case (st)
                IDLE: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        err_code <= LDR_E_NONE;
                        wr_cnt   <= 16'd0;
                        mem_a    <= A0;
                    end
                end
                LEN_LO: if (xfer) len[7:0] <= s_data;
                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= s_data;
                        if (len_ovf) err_code <= LDR_E_OVF;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        mem_we <= 1'b1;
                        mem_d  <= s_data;
                        wr_cnt <= wr_cnt + 16'd1;
                    end
                end
                CSUM: if (xfer && (s_data != sum)) err_code <= LDR_E_CSUM;
                DONE: done <= 1'b1;
                ERR:  err  <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ej32_rom_loader.sv
// Directed and randomized frames against a frame-level model of the loader.
module tb_ej32_rom_loader;

    localparam int ROM_SZ = 8192;
    localparam int BASE_A = 0;
    localparam int MSZ    = $clog2(ROM_SZ);

    logic           clk     = 1'b0;
    logic           rst     = 1'b0;
    logic           start   = 1'b0;
    logic           s_valid = 1'b0;
    logic [7:0]     s_data  = 8'd0;
    logic           s_ready;
    logic           mem_we;
    logic [MSZ-1:0] mem_a;
    logic [7:0]     mem_d;
    logic           busy;
    logic           done;
    logic           err;
    logic [1:0]     err_code;
    logic [15:0]    wr_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit stalled;

    logic [MSZ-1:0] wa[$];
    logic [7:0]     wd[$];
    int             wc[$];

    ej32_rom_loader #(.ROM_SZ(ROM_SZ), .BASE_A(BASE_A)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .mem_we   (mem_we),
        .mem_a    (mem_a),
        .mem_d    (mem_d),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .wr_cnt   (wr_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Write log sampled mid-cycle: each mem_we pulse lasts exactly one cycle.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            wa.push_back(mem_a);
            wd.push_back(mem_d);
            wc.push_back(cyc);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"},  32'(s_ready),  32'd0);
        check({tag, "_mem_we"},   32'(mem_we),   32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
        check({tag, "_mem_a"},    32'(mem_a),    32'(BASE_A));
        check({tag, "_mem_d"},    32'(mem_d),    32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_wr_cnt"},   32'(wr_cnt),   32'd0);
    endtask

    // Offer one byte with random idle gaps until the DUT takes it.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit mstart);
        int t;
        bit sent;
        t    = 0;
        sent = 1'b0;
        while (!sent && t < 200) begin
            s_valid = ($urandom_range(99) >= gap);
            s_data  = s_valid ? b : 8'($urandom);
            start   = mstart && ($urandom_range(99) < 20);
            @(negedge clk);
            sent = s_valid && s_ready;
            @(posedge clk);
            #1;
            t++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        stalled = !sent;
        check("byte_accept", 32'(sent), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] len, input logic [7:0] pl[$],
                             input logic [7:0] cs, input int gap, input bit mstart);
        logic [7:0] fr[$];
        logic [7:0] esum;
        bit         ovf;
        bit         edone;
        int         nexp;
        int         t;
        ovf  = int'(len) > (ROM_SZ - BASE_A);
        esum = 8'd0;
        foreach (pl[i]) esum += pl[i];
        edone = !ovf && (cs == esum);
        nexp  = ovf ? 0 : pl.size();
        fr.push_back(len[7:0]);
        fr.push_back(len[15:8]);
        if (!ovf) begin
            foreach (pl[i]) fr.push_back(pl[i]);
            fr.push_back(cs);
        end

        wa.delete(); wd.delete(); wc.delete();
        stalled = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_on"}, 32'(busy), 32'd1);
        foreach (fr[i]) if (!stalled) send_byte(fr[i], gap, mstart);

        t = 0;
        while (!(done || err) && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({tag, "_latency"},  32'(t),        32'd1);
        check({tag, "_done"},     32'(done),     32'(edone));
        check({tag, "_err"},      32'(err),      32'(!edone));
        check({tag, "_err_code"}, 32'(err_code), ovf ? 32'd1 : (edone ? 32'd0 : 32'd2));
        check({tag, "_wr_cnt"},   32'(wr_cnt),   32'(nexp));
        check({tag, "_busy_off"}, 32'(busy),     32'd0);
        check({tag, "_s_ready"},  32'(s_ready),  32'd0);
        check({tag, "_nwrites"},  32'(wa.size()), 32'(nexp));
        foreach (wa[i]) begin
            if (i < nexp) begin
                check({tag, "_addr"}, 32'(wa[i]), 32'(BASE_A + i));
                check({tag, "_data"}, 32'(wd[i]), 32'(pl[i]));
                if (gap == 0 && !mstart && i > 0)
                    check({tag, "_b2b"}, 32'(wc[i]), 32'(wc[i-1] + 1));
            end
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] s;
        logic [15:0] l;

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        q.delete();
        q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
        run_frame("normal", 16'd4, q, 8'hAA, 0, 1'b0);
        run_frame("badsum", 16'd4, q, 8'hAB, 0, 1'b0);

        q.delete();
        run_frame("ovf", 16'h2001, q, 8'h00, 0, 1'b0);
        run_frame("zero", 16'd0, q, 8'h00, 0, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            check("zero_extra_ready", 32'(s_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        check("zero_extra_done", 32'(done), 32'd1);

        q.delete();
        q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
        run_frame("gaps", 16'd4, q, 8'hAA, 40, 1'b1);

        // Exactly fills the memory: the last write lands on the top address.
        q.delete();
        s = 8'd0;
        for (int i = 0; i < ROM_SZ - BASE_A; i++) begin
            q.push_back(8'($urandom));
            s += q[i];
        end
        run_frame("full", 16'(ROM_SZ - BASE_A), q, s, 0, 1'b0);

        for (int f = 0; f < 4; f++) begin
            q.delete();
            s = 8'd0;
            l = 16'($urandom_range(24, 1));
            for (int i = 0; i < int'(l); i++) begin
                q.push_back(8'($urandom));
                s += q[i];
            end
            if ($urandom_range(1) == 1) s = s ^ 8'(1 << $urandom_range(7));
            run_frame("rand", l, q, s, 30, 1'b1);
        end

        q.delete();
        l = 16'($urandom_range(65535, ROM_SZ - BASE_A + 1));
        run_frame("rand_ovf", l, q, 8'h00, 20, 1'b0);

        // Reset asserted mid-load, between clock edges.
        wa.delete(); wd.delete(); wc.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_byte(8'h04, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h5A, 0, 1'b0);
        send_byte(8'hA5, 0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset("midrst");
        check("midrst_nwrites", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check("midrst_w0", 32'(wd[0]), 32'h5A);
            check("midrst_w1", 32'(wd[1]), 32'hA5);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        q.delete();
        q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
        run_frame("after_rst", 16'd4, q, 8'hAA, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ej32_rom_loader.md
Name: ej32_rom_loader

Overview:
- Writer side of the eJ32 8K byte image memory: streams an eForth image from a byte source (UART RX or debug bridge) into the EBR through its write port.
- Framing: 16-bit length, payload bytes, 8-bit additive checksum.
- Holds the core off (busy) until the image is committed.
- Result reported as done or err with a cause code.

Parameters:
- ROM_SZ, 8192, memory size in bytes; power of two.
- BASE_A, 0, first byte address written; must be < ROM_SZ.
- MSZ, $clog2(ROM_SZ), address width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low: asserts on falling edge, releases synchronously to clk.
- start  in  1  one-cycle pulse; arms a load. Ignored while busy.
- s_valid  in  1  source byte valid.
- s_data  in  8  source byte.
- s_ready  out  1  loader accepts the byte this cycle (transfer = s_valid & s_ready).
- mem_we  out  1  write strobe to the image memory.
- mem_a  out  MSZ  write byte address.
- mem_d  out  8  write data.
- busy  out  1  load in progress; core held in reset while high.
- done  out  1  sticky: image written, checksum matched.
- err  out  1  sticky: load failed.
- err_code  out  2  1 = length overflow, 2 = checksum mismatch, 0 = none.
- wr_cnt  out  16  payload bytes written in the current or last load.

Behaviour:
- Reset values: s_ready, mem_we, busy, done, err = 0; mem_a = BASE_A; mem_d, err_code, wr_cnt = 0; state IDLE.
- States and transitions:
  - IDLE: start → LEN_LO. Clears done, err, err_code, wr_cnt and the checksum accumulator; mem_a = BASE_A.
  - LEN_LO: on transfer, len[7:0] = byte → LEN_HI.
  - LEN_HI: on transfer, len[15:8] = byte.
    - If len > ROM_SZ - BASE_A → ERR, err_code = 1.
    - Else if len = 0 → CSUM.
    - Else → DATA.
  - DATA: each transfer is written to memory and added into the checksum. Last byte (wr_cnt+1 = len) → CSUM.
  - CSUM: on transfer, byte == sum[7:0] → DONE; else → ERR, err_code = 2.
  - DONE / ERR: set the matching sticky flag. Return to IDLE next cycle; the flags persist until the next start.
- Handshake:
  - s_ready = 1 exactly in LEN_LO, LEN_HI, DATA, CSUM; combinational from state.
  - s_valid may drop at any time; no byte is lost or duplicated.
  - No transfer occurs in IDLE, DONE or ERR.
- Write timing:
  - Payload byte accepted at cycle t → mem_we = 1 at t+1 with mem_d = that byte and mem_a = address of that byte (all registered).
  - mem_a increments after each write; wr_cnt increments at t+1.
  - Back-to-back accepts give back-to-back writes.
- Arithmetic:
  - Checksum is the 8-bit sum mod 256 of payload bytes only; length bytes are excluded.
  - Address never wraps: the overflow check guarantees BASE_A+len-1 ≤ ROM_SZ-1.
- busy = 1 from the cycle after start through the cycle of entering DONE or ERR.
- start during busy: ignored, no state change.
- Reset mid-load:
  - Immediate abort to the reset values.
  - Bytes already written stay in memory.
  - done = 0, so the image is not trusted.
- No timeout. A stalled source keeps busy high indefinitely; the supervisor recovers via rst.

Decomposition:
- ej32_pkg gains:
  - typedef ldr_st_t, an enum of IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR;
  - constants LDR_E_NONE=0, LDR_E_OVF=1, LDR_E_CSUM=2.
- One natural sub-module: ej32_ldr_csum, an 8-bit accumulator with clear and add-enable, reused by a future image-dump reader.
- Everything else stays flat in one module.

Test Plan:
- Normal load: start; stream 04 00 11 22 33 44 AA.
  - Writes (0,11), (1,22), (2,33), (3,44) on consecutive cycles.
  - Then done = 1, err = 0, wr_cnt = 4, busy = 0.
- Bad checksum: same frame with final byte AB.
  - All four writes occur.
  - err = 1, err_code = 2, done = 0.
- Overflow: start; stream 01 20 (len = 0x2001).
  - err = 1, err_code = 1 immediately after the second byte.
  - No mem_we pulse; s_ready = 0 afterwards.
- Zero length: stream 00 00 00.
  - done = 1, wr_cnt = 0, no writes.
  - A 4th byte is not accepted (s_ready = 0).
- Backpressure/gaps: normal frame with s_valid toggled randomly, plus a start pulse mid-frame.
  - Identical writes and result to the normal load; the extra start has no effect.
- Reset mid-load: assert rst after 2 payload bytes.
  - Outputs go to reset values asynchronously; done = 0.
  - A following full load completes correctly from BASE_A.
